// File: rtl/shift_reg_pkg.sv
// Shared constants for the quadrature phase generator: phase-select codes
// and the Johnson counter reset value, plus the counter step function.
package shift_reg_pkg;

    localparam logic [1:0] PH_0          = 2'b00;
    localparam logic [1:0] PH_90         = 2'b01;
    localparam logic [1:0] PH_180        = 2'b10;
    localparam logic [1:0] PH_270        = 2'b11;
    localparam logic [1:0] JOHNSON_RESET = 2'b00;

    // Two-bit Johnson step: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] johnson_next(input logic [1:0] s);
        return {s[0], ~s[1]};
    endfunction

endpackage

// File: rtl/shift_reg_mux4to1.sv
// Combinational 4:1 selector used to pick one of the four clock phases.
module mux4to1
    import shift_reg_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       o
);

    // Select one input by phase code.
    always_comb begin
        o = a;
        case (sel)
            PH_0:    o = a;
            PH_90:   o = b;
            PH_180:  o = c;
            PH_270:  o = d;
            default: o = a;
        endcase
    end

endmodule

// File: rtl/shift_reg.sv
// clk/4 quadrature generator built on a 2-bit Johnson counter.
// Optional registered phase selector enabled by macro SHIFT_REG_PHASE_MUX_EN.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter logic [1:0] SEL_RESET = 2'b00
) (
    input  logic       clk,
    input  logic       init,
    input  logic [1:0] phasesel,
    output logic       phase0,
    output logic       phase90,
    output logic       phase180,
    output logic       phase270,
    output logic       phase_out
);

    logic [1:0] s;

    // Johnson counter state; every code lies on the cycle, so no recovery logic.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            s <= JOHNSON_RESET;
        end else begin
            s <= johnson_next(s);
        end
    end

    // Phases come straight from flops or a single inverter to stay glitch-free.
    assign phase0   = s[0];
    assign phase90  = s[1];
    assign phase180 = ~s[0];
    assign phase270 = ~s[1];

`ifdef SHIFT_REG_PHASE_MUX_EN
    logic [1:0] sel;

    // Registered select gives one cycle of latency and never touches the counter.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sel <= SEL_RESET;
        end else begin
            sel <= phasesel;
        end
    end

    mux4to1 u_mux (
        .a   (phase0),
        .b   (phase90),
        .c   (phase180),
        .d   (phase270),
        .sel (sel),
        .o   (phase_out)
    );
`else
    logic unused_phasesel;
    assign unused_phasesel = ^phasesel;
    assign phase_out       = phase0;
`endif

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: vector table, async reset sequence,
// randomized phase selection against a cycle-count reference model.
module tb_shift_reg;

    logic       clk = 1'b0;
    logic       init;
    logic [1:0] phasesel;
    logic       phase0, phase90, phase180, phase270, phase_out;

    logic       init3;
    logic [1:0] phasesel3;
    logic       p0_3, p90_3, p180_3, p270_3, pout_3;

    int checks = 0;
    int passes = 0;

    int         n_m;    // edges since reset release
    logic [1:0] sel_m;  // modelled select register

    always #5 clk = ~clk;

    shift_reg dut (
        .clk(clk), .init(init), .phasesel(phasesel),
        .phase0(phase0), .phase90(phase90), .phase180(phase180),
        .phase270(phase270), .phase_out(phase_out)
    );

    shift_reg #(.SEL_RESET(2'b11)) dut3 (
        .clk(clk), .init(init3), .phasesel(phasesel3),
        .phase0(p0_3), .phase90(p90_3), .phase180(p180_3),
        .phase270(p270_3), .phase_out(pout_3)
    );

    // Reference: phase0 is high for edges 1,2 of every 4; phase90 one edge later.
    function automatic logic ref_phase(input int n, input logic [1:0] p);
        logic r0, r90;
        r0  = ((n + 3) % 4) < 2;
        r90 = ((n + 2) % 4) < 2;
        case (p)
            2'b00:   return r0;
            2'b01:   return r90;
            2'b10:   return ~r0;
            default: return ~r90;
        endcase
    endfunction

    function automatic logic ref_out();
`ifdef SHIFT_REG_PHASE_MUX_EN
        return ref_phase(n_m, sel_m);
`else
        return ref_phase(n_m, 2'b00);
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, n_m);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".phase0"},    phase0,    ref_phase(n_m, 2'b00));
        chk({tag, ".phase90"},   phase90,   ref_phase(n_m, 2'b01));
        chk({tag, ".phase180"},  phase180,  ref_phase(n_m, 2'b10));
        chk({tag, ".phase270"},  phase270,  ref_phase(n_m, 2'b11));
        chk({tag, ".phase_out"}, phase_out, ref_out());
    endtask

    task automatic tick();
        logic [1:0] nxt;
        nxt = phasesel;
        @(posedge clk);
        #1;
        if (init) begin
            n_m   = 0;
            sel_m = 2'b00;
        end else begin
            n_m   = n_m + 1;
            sel_m = nxt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        init = 1'b1;
        tick();
        @(negedge clk);
        init  = 1'b0;
        n_m   = 0;
        sel_m = 2'b00;
    endtask

    typedef struct {
        logic [1:0] psel;
        logic       e0;
        logic       e90;
    } vec_t;

    vec_t tbl[8];
    int   rise0, rise90;
    logic prev0, prev90;

    initial begin
        tbl[0] = '{2'b00, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 1'b1, 1'b1};
        tbl[2] = '{2'b10, 1'b0, 1'b1};
        tbl[3] = '{2'b11, 1'b0, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 1'b0};
        tbl[5] = '{2'b10, 1'b1, 1'b1};
        tbl[6] = '{2'b01, 1'b0, 1'b1};
        tbl[7] = '{2'b11, 1'b0, 1'b0};

        init      = 1'b1;
        init3     = 1'b1;
        phasesel  = 2'b00;
        phasesel3 = 2'b00;
        n_m       = 0;
        sel_m     = 2'b00;

        // Reset held across an edge: state stays at reset values.
        tick();
        tick();
        chk_all("reset");
        chk("sel_reset11.phase270", p270_3, 1'b1);
`ifdef SHIFT_REG_PHASE_MUX_EN
        chk("sel_reset11.phase_out", pout_3, 1'b1);
`else
        chk("sel_reset11.phase_out", pout_3, 1'b0);
`endif

        // Eight-edge golden sequence from a fresh release.
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < 8; i++) begin
            phasesel = tbl[i].psel;
            tick();
            chk("tbl.phase0",  phase0,  tbl[i].e0);
            chk("tbl.phase90", phase90, tbl[i].e90);
            chk_all("tbl");
            #2;
        end

        // Asynchronous reset pulse between edges after five more cycles.
        for (int i = 0; i < 5; i++) tick();
        #3;
        init = 1'b1;
        #1;
        chk("async.phase0",   phase0,   1'b0);
        chk("async.phase90",  phase90,  1'b0);
        chk("async.phase180", phase180, 1'b1);
        chk("async.phase270", phase270, 1'b1);
        #1;
        init  = 1'b0;
        n_m   = 0;
        sel_m = 2'b00;
        tick();
        chk("async.first_edge_phase0", phase0, 1'b1);
        chk_all("async");

        // Hand sequence: select 180 then 90, each taking effect one edge later.
        phasesel = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("sel180");
        end
        phasesel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("sel90");
        end

        // Random select over 100 cycles from a fresh reset; count rising edges.
        do_reset();
        rise0  = 0;
        rise90 = 0;
        prev0  = phase0;
        prev90 = phase90;
        for (int i = 0; i < 100; i++) begin
            phasesel = 2'($urandom_range(0, 3));
            tick();
            chk_all("rand");
            if (phase0 && !prev0) rise0++;
            if (phase90 && !prev90) rise90++;
            prev0  = phase0;
            prev90 = phase90;
        end
        checks++;
        if (rise0 == 25) passes++;
        else $display("FAIL rise_count.phase0: got %0d expected 25", rise0);
        checks++;
        if (rise90 == 25) passes++;
        else $display("FAIL rise_count.phase90: got %0d expected 25", rise90);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
